mvm_seq_mac: RTL

Sequential, parametrised successor to the single-row saturating dot-product unit. It computes a full R×S matrix by S-vector product, v = W·u, with unsigned N-bit elements. The work is time-multiplexed over L parallel MAC lanes, with valid/ready handshakes on both input and output. The block adds a run-time saturate/wrap mode and a per-result overflow flag, and it is the matrix-vector engine feeding the LSTM gate datapath.

---
 rtl/mvm_pkg.sv | 51 +++++
 rtl/mvm_mac_lane.sv | 26 ++
 rtl/mvm_seq_mac.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// Shared types and arithmetic helpers for the sequential matrix-vector MAC.
// Helpers take a run-time width n (n <= N_MAX) so any element width fits.
package mvm_pkg;

   localparam int N_MAX = 8;

   typedef logic [N_MAX-1:0]   elem_t;
   typedef logic [2*N_MAX-1:0] prod_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   function automatic elem_t mask_n(input int n);
      return elem_t'((32'd1 << n) - 32'd1);
   endfunction

   // Product does not fit in n bits.
   function automatic logic prod_ovf(input prod_t p, input int n);
      return (p >> n) != '0;
   endfunction

   function automatic elem_t sat_prod(input prod_t p, input int n);
      return prod_ovf(p, n) ? mask_n(n) : (p[N_MAX-1:0] & mask_n(n));
   endfunction

   function automatic elem_t wrap_prod(input prod_t p, input int n);
      return p[N_MAX-1:0] & mask_n(n);
   endfunction

   // Carry out of an n-bit addition.
   function automatic logic add_ovf(input elem_t a, input elem_t b,
                                    input int n);
      logic [N_MAX:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >> n) != '0;
   endfunction

   function automatic elem_t sat_addN(input elem_t a, input elem_t b,
                                      input int n);
      return add_ovf(a, b, n) ? mask_n(n) : ((a + b) & mask_n(n));
   endfunction

   function automatic elem_t wrap_addN(input elem_t a, input elem_t b,
                                       input int n);
      return (a + b) & mask_n(n);
   endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One MAC lane: N x N unsigned multiply, mode-adjusted to N bits.
// Ports: i_w/i_u operands, i_sat_en mode, o_prod result, o_prod_ovf flag.
module mvm_mac_lane
   import mvm_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] i_w,
   input  logic [N-1:0] i_u,
   input  logic         i_sat_en,
   output logic [N-1:0] o_prod,
   output logic         o_prod_ovf
);

   prod_t w_p;
   elem_t w_r;

   assign w_p = prod_t'(i_w) * prod_t'(i_u);

   assign w_r = i_sat_en ? sat_prod(w_p, N)
                         : wrap_prod(w_p, N);

   assign o_prod     = w_r[N-1:0];
   assign o_prod_ovf = prod_ovf(w_p, N);

endmodule

// File: rtl/mvm_seq_mac.sv
// Sequential R x S matrix by S-vector product over L MAC lanes.
// Ports: CLOCK_50/reset_n, in_valid/in_ready + sat_en/w/u in,
//        out_valid/out_ready + v/ovf out.
module mvm_seq_mac
   import mvm_pkg::*;
#(
   parameter int N = 8,
   parameter int S = 4,
   parameter int R = 4,
   parameter int L = 2
) (
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sat_en,
   input  logic [R*S*N-1:0] w,
   input  logic [S*N-1:0]   u,
   output logic [R*N-1:0]   v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ovf
);

   localparam int C  = S / L;
   localparam int CW = (C > 1) ? $clog2(C) : 1;
   localparam int RW = (R > 1) ? $clog2(R) : 1;

   if ((S % L) != 0) begin : g_chk_l
      $error("mvm_seq_mac: L must divide S");
   end
   if (N > N_MAX) begin : g_chk_n
      $error("mvm_seq_mac: N exceeds mvm_pkg::N_MAX");
   end

   state_t           r_state;
   state_t           w_next;
   logic [R*S*N-1:0] r_w;
   logic [S*N-1:0]   r_u;
   logic             r_sat;
   logic [RW-1:0]    r_row;
   logic [CW-1:0]    r_col;
   logic [N-1:0]     r_acc;
   logic [R*N-1:0]   r_v;
   logic             r_ovf;

   logic [L*N-1:0]   w_wl;
   logic [L*N-1:0]   w_ul;
   logic [L*N-1:0]   w_prod;
   logic [L-1:0]     w_povf;
   elem_t            w_pk;
   elem_t            w_sum;
   logic             w_cov;
   logic             w_accept;
   logic             w_last_col;
   logic             w_last_row;

   assign w_accept   = (r_state == IDLE) && in_valid;
   assign w_last_col = (r_col == CW'(C - 1));
   assign w_last_row = (r_row == RW'(R - 1));

   // Operand select for the current chunk of the current row.
   always_comb begin
      w_wl = '0;
      w_ul = '0;
      for (int k = 0; k < L; k++) begin
         w_wl[k*N +: N] =
            r_w[(int'(r_row)*S + int'(r_col)*L + k)*N +: N];
         w_ul[k*N +: N] =
            r_u[(int'(r_col)*L + k)*N +: N];
      end
   end

   for (genvar k = 0; k < L; k++) begin : g_lane
      mvm_mac_lane #(
         .N(N)
      ) u_lane (
         .i_w       (w_wl[k*N +: N]),
         .i_u       (w_ul[k*N +: N]),
         .i_sat_en  (r_sat),
         .o_prod    (w_prod[k*N +: N]),
         .o_prod_ovf(w_povf[k])
      );
   end

   // Chunk reduction onto the accumulator. A chain of clamped adds
   // equals min(total, max) because all terms are non-negative.
   always_comb begin
      w_sum = elem_t'(r_acc);
      w_cov = 1'b0;
      w_pk  = '0;
      for (int k = 0; k < L; k++) begin
         w_pk  = elem_t'(w_prod[k*N +: N]);
         w_cov = w_cov | w_povf[k] | add_ovf(w_sum, w_pk, N);
         w_sum = r_sat ? sat_addN(w_sum, w_pk, N)
                       : wrap_addN(w_sum, w_pk, N);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_next = COMPUTE;
            end
         end
         COMPUTE: begin
            if (w_last_col && w_last_row) begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_w   <= '0;
         r_u   <= '0;
         r_sat <= 1'b0;
         r_row <= '0;
         r_col <= '0;
         r_acc <= '0;
         r_v   <= '0;
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_w   <= w;
         r_u   <= u;
         r_sat <= sat_en;
         r_row <= '0;
         r_col <= '0;
         r_acc <= '0;
         r_v   <= '0;
         r_ovf <= 1'b0;
      end else if (r_state == COMPUTE) begin
         r_ovf <= r_ovf | w_cov;
         if (w_last_col) begin
            r_v[int'(r_row)*N +: N] <= w_sum[N-1:0];
            r_acc <= '0;
            r_col <= '0;
            r_row <= r_row + RW'(1);
         end else begin
            r_acc <= w_sum[N-1:0];
            r_col <= r_col + CW'(1);
         end
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign v         = r_v;
   assign ovf       = r_ovf;

endmodule
